// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//   div_state_e       - divider FSM states
//   DIV_WIDTH_DEFAULT - default operand/result width
//   cnt_width()       - iteration counter width for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH_DEFAULT = 32;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sub_cla.sv
// cla4: 4-bit carry-lookahead adder cell.
//   a, b  in  4  addends
//   c_in  in  1  carry in
//   sum   out 4  sum
//   c_out out 1  carry out
//
// sub_cla: N-bit subtractor a - b built as a ripple of cla4 cells,
// computed as a + ~b + 1.
//   a, b      in  N  minuend, subtrahend
//   diff      out N  a - b (mod 2^N)
//   carry_out out 1  1 when a >= b (no borrow)
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign sum   = p ^ c[3:0];
  assign c_out = c[4];

endmodule

module sub_cla #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         carry_out
);

  localparam int NP = ((N + 3) / 4) * 4;
  localparam int NC = NP / 4;

  logic [NP-1:0] a_pad;
  logic [NP-1:0] b_inv;
  logic [NP-1:0] sum;
  logic [NC:0]   carry;

  // Pad bits see a=0 and ~b=1, so they pass the bit-N carry through unchanged.
  assign a_pad    = NP'(a);
  assign b_inv    = ~(NP'(b));
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < NC; i++) begin : g_cell
    cla4 u_cla4 (
      .a     (a_pad[4*i +: 4]),
      .b     (b_inv[4*i +: 4]),
      .c_in  (carry[i]),
      .sum   (sum[4*i +: 4]),
      .c_out (carry[i+1])
    );
  end

  assign diff = sum[N-1:0];

  if (NP > N) begin : g_pad
    // Each pad sum bit equals ~carry(N) and the final carry equals carry(N),
    // so this is exactly the carry out of bit N-1.
    assign carry_out = carry[NC] & ~(|sum[NP-1:N]);
  end else begin : g_nopad
    assign carry_out = carry[NC];
  end

endmodule

// File: rtl/seq_div32.sv
// seq_div32: unsigned multi-cycle restoring divider, one quotient bit per clock.
//   clk          in  1      clock, rising edge
//   rst_n        in  1      asynchronous active-low reset
//   start_in     in  1      request, accepted while ready_o=1
//   dividend_in  in  WIDTH  dividend, sampled on accept
//   divisor_in   in  WIDTH  divisor, sampled on accept
//   ready_o      out 1      idle, can accept
//   done_o       out 1      one-cycle pulse, results valid
//   quotient_o   out WIDTH  quotient (all-ones on divide by zero)
//   remainder_o  out WIDTH  remainder (dividend on divide by zero)
//   div_zero_o   out 1      divisor was zero
//
// state | meaning
// IDLE  | ready_o=1, waiting for start_in
// CALC  | one subtract-and-shift iteration per cycle, WIDTH cycles
// DONE  | done_o=1 for one cycle, results valid
module seq_div32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_e       state_q;
  div_state_e       state_d;
  logic             accept;
  logic             calc_last;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] divisor_q;

  logic [WIDTH:0]   shifted_rem;
  logic [WIDTH:0]   trial_diff;
  logic             trial_carry;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quot_next;

  // The shifted remainder is WIDTH+1 bits so the bit leaving rem still takes
  // part in the compare; divisors >= 2^(WIDTH-1) would overflow otherwise.
  assign shifted_rem = {rem_q, quot_q[WIDTH-1]};

  sub_cla #(
    .N (WIDTH + 1)
  ) u_sub (
    .a         (shifted_rem),
    .b         ({1'b0, divisor_q}),
    .diff      (trial_diff),
    .carry_out (trial_carry)
  );

  // Without a borrow the difference is below the divisor, so its MSB is zero;
  // including it changes nothing and keeps the whole difference in use.
  assign no_borrow = trial_carry & ~trial_diff[WIDTH];
  assign rem_next  = no_borrow ? trial_diff[WIDTH-1:0] : shifted_rem[WIDTH-1:0];
  assign quot_next = {quot_q[WIDTH-2:0], no_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    calc_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          accept  = 1'b1;
          state_d = (divisor_in == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST) begin
          calc_last = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready_o = (state_q == IDLE);
  assign done_o  = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else if (accept) begin
      divisor_q  <= divisor_in;
      cnt_q      <= '0;
      div_zero_o <= 1'b0;
      if (divisor_in == '0) begin
        quotient_o  <= '1;
        remainder_o <= dividend_in;
        div_zero_o  <= 1'b1;
      end else begin
        rem_q  <= '0;
        quot_q <= dividend_in;
      end
    end else if (state_q == CALC) begin
      rem_q  <= rem_next;
      quot_q <= quot_next;
      if (calc_last) begin
        cnt_q       <= '0;
        quotient_o  <= quot_next;
        remainder_o <= rem_next;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
module tb_seq_div32;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_in;
  logic [31:0] dividend_in;
  logic [31:0] divisor_in;
  logic        ready_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;
  logic        div_zero_o;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;
  int   done_cnt;

  seq_div32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_in    (start_in),
    .dividend_in (dividend_in),
    .divisor_in  (divisor_in),
    .ready_o     (ready_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done_o) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done_o=1 expected no pending operation (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          check("quotient", quotient_o, e.q);
          check("remainder", remainder_o, e.r);
          check("div_zero", div_zero_o, e.dz);
          check("done_latency", cyc - e.acc + 1, e.lat);
          check("ready_in_done", ready_o, 1'b0);
          @(negedge clk);
          check("ready_after_done", ready_o, 1'b1);
        end
      end
    end
  end

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = 33;
    end
    e.acc = 0;
    return e;
  endfunction

  // Waits for ready, presents one request, returns the accept edge number.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz,
                       input bit do_push, output int acc);
    exp_t e;
    int n;
    n = 0;
    while (!ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got ready_o=0 expected 1 within 300 cycles");
    end
    start_in    = 1'b1;
    dividend_in = a;
    divisor_in  = b;
    @(posedge clk);
    #1;
    acc = cyc;
    if (do_push) begin
      e.q = eq; e.r = er; e.dz = edz; e.acc = acc;
      e.lat = (b == 0) ? 1 : 33;
      sb.push_back(e);
    end
    start_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int acc;
    int prev_acc;
    int prev_lat;
    int dc;
    int rst_edge;
    int n;
    logic [31:0] a;
    logic [31:0] b;
    exp_t e;

    checks = 0; errors = 0; done_cnt = 0;
    rst_n = 1'b0; start_in = 1'b0; dividend_in = '0; divisor_in = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready_o, 1'b1);
    check("reset_done", done_o, 1'b0);
    check("reset_quotient", quotient_o, 0);
    check("reset_remainder", remainder_o, 0);
    check("reset_div_zero", div_zero_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, acc);
    drain();
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, acc);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, acc);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b1, acc);
    issue(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, acc);
    issue(32'd12345678, 32'd1000, 32'd12345, 32'd678, 1'b0, 1'b1, acc);
    issue(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1, acc);
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1, acc);
    drain();

    // start_in during CALC must be ignored
    dc = done_cnt;
    issue(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b1, acc);
    repeat (5) @(negedge clk);
    start_in = 1'b1; dividend_in = 32'd50; divisor_in = 32'd5;
    @(negedge clk);
    start_in = 1'b0;
    drain();
    repeat (40) @(negedge clk);
    check("ignored_start_done_count", done_cnt - dc, 1);

    // Reset during CALC aborts with no done pulse
    issue(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, acc);
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", ready_o, 1'b1);
    check("midrst_done", done_o, 1'b0);
    check("midrst_quotient", quotient_o, 0);
    check("midrst_remainder", remainder_o, 0);
    check("midrst_div_zero", div_zero_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    rst_edge = cyc;
    issue(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 1'b1, acc);
    check("first_accept_after_reset", acc, rst_edge + 1);
    drain();

    // Back-to-back with start_in held high
    prev_acc = 0;
    prev_lat = 0;
    start_in = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 255);
        default: b = $urandom;
      endcase
      a = $urandom;
      dividend_in = a;
      divisor_in  = b;
      n = 0;
      while (!ready_o && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!ready_o) begin
        checks++;
        errors++;
        $display("FAIL b2b_ready_timeout: got ready_o=0 expected 1 within 100 cycles");
        break;
      end
      @(posedge clk);
      #1;
      acc = cyc;
      e = model(a, b);
      e.acc = acc;
      sb.push_back(e);
      if (i > 0) check("b2b_spacing", acc - prev_acc, prev_lat + 1);
      prev_acc = acc;
      prev_lat = e.lat;
      @(negedge clk);
    end
    start_in = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
